// File: rtl/dac_update_scheduler_if.sv
// Signal bundle between the sample source / SPI master and dac_update_scheduler.
// slave = scheduler view, master = surrounding environment view.
interface dac_update_scheduler_if #(
    parameter int IN_BITS  = 12,
    parameter int OUT_BITS = 8,
    parameter int DIV_BITS = 8
);
    // Handshake: a sample transfers on every clock where in_valid && in_ready; in_ready is
    // tied high so the newest sample always wins. spi_start is held until spi_cs is seen low.
    logic [IN_BITS-1:0]  in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DIV_BITS-1:0] rate_div;
    logic                spi_cs;
    logic                spi_start;
    logic [OUT_BITS-1:0] spi_data;
    logic                busy;
    logic                done;
    logic [7:0]          drop_cnt;
    logic [1:0]          dbg_state;

    modport slave (
        input  in_data, in_valid, rate_div, spi_cs,
        output in_ready, spi_start, spi_data, busy, done, drop_cnt, dbg_state
    );

    modport master (
        output in_data, in_valid, rate_div, spi_cs,
        input  in_ready, spi_start, spi_data, busy, done, drop_cnt, dbg_state
    );
endinterface

// File: rtl/dac_update_scheduler.sv
// Saturating offset-binary DAC scheduler feeding an output-only SPI master at a divided rate.
// Optional DAC_SKIP_UNCHANGED_EN suppresses transfers whose code equals the last one sent.
module dac_update_scheduler #(
    parameter int IN_BITS  = 12,
    parameter int OUT_BITS = 8,
    parameter int DIV_BITS = 8
) (
    input logic clk,
    input logic reset_n,
    dac_update_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam int CODE_MAX_I = (1 << (OUT_BITS - 1)) - 1;
    localparam logic signed [IN_BITS-1:0] CODE_MAX = IN_BITS'(CODE_MAX_I);
    localparam logic signed [IN_BITS-1:0] CODE_MIN = ~CODE_MAX;
    localparam logic [OUT_BITS-1:0] MIDSCALE = {1'b1, {(OUT_BITS - 1){1'b0}}};

    state_e              state_q, state_d;
    logic                spi_start_q, spi_start_d;
    logic                done_q, done_d;
    logic [OUT_BITS-1:0] spi_data_q, spi_data_d;
    logic [OUT_BITS-1:0] pending_q, pending_d;
    logic                pending_valid_q, pending_valid_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [DIV_BITS-1:0] rate_cnt_q, rate_cnt_d;

    logic signed [IN_BITS-1:0] in_s, clamp_s;
    logic [OUT_BITS-1:0]       in_code;
    logic                      tick, decide, skip, launch;

    always_comb begin
        in_s = $signed(bus.in_data);
        if (in_s > CODE_MAX)      clamp_s = CODE_MAX;
        else if (in_s < CODE_MIN) clamp_s = CODE_MIN;
        else                      clamp_s = in_s;
        in_code = {~clamp_s[OUT_BITS-1], clamp_s[OUT_BITS-2:0]};
    end

    // decide consumes pending whether or not the code is actually launched.
    assign tick   = (rate_cnt_q == '0);
    assign decide = (state_q == IDLE) && tick && pending_valid_q && bus.spi_cs;
    assign launch = decide && !skip;

`ifdef DAC_SKIP_UNCHANGED_EN
    logic [OUT_BITS-1:0] last_sent_q, last_sent_d;

    assign skip        = (pending_q == last_sent_q);
    assign last_sent_d = launch ? pending_q : last_sent_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_sent_q <= MIDSCALE;
        else          last_sent_q <= last_sent_d;
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            spi_start_q     <= 1'b0;
            done_q          <= 1'b0;
            spi_data_q      <= MIDSCALE;
            pending_q       <= MIDSCALE;
            pending_valid_q <= 1'b0;
            drop_cnt_q      <= 8'd0;
            rate_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            spi_start_q     <= spi_start_d;
            done_q          <= done_d;
            spi_data_q      <= spi_data_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            drop_cnt_q      <= drop_cnt_d;
            rate_cnt_q      <= rate_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch)      state_d = START;
            START:   if (!bus.spi_cs) state_d = ACTIVE;
            ACTIVE:  if (bus.spi_cs)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        spi_start_d = 1'b0;
        done_d      = 1'b0;
        spi_data_d  = spi_data_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    spi_start_d = 1'b1;
                    spi_data_d  = pending_q;
                end
            end
            START:   spi_start_d = bus.spi_cs;
            ACTIVE:  done_d      = bus.spi_cs;
            default: ;
        endcase
    end

    // The timer free-runs in every state, so a tick missed while busy is simply lost.
    always_comb begin
        rate_cnt_d      = tick ? bus.rate_div : rate_cnt_q - DIV_BITS'(1);
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        drop_cnt_d      = drop_cnt_q;
        if (bus.in_valid) begin
            pending_d       = in_code;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !decide && (drop_cnt_q != 8'hFF))
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (decide) begin
            pending_valid_d = 1'b0;
        end
    end

    assign bus.in_ready  = 1'b1;
    assign bus.spi_start = spi_start_q;
    assign bus.spi_data  = spi_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler with a behavioural SPI-master chip-select model.
// Build with DAC_SKIP_UNCHANGED_EN defined to exercise the repeat-suppression variant.
module tb_dac_update_scheduler;
    localparam int IN_BITS  = 12;
    localparam int OUT_BITS = 8;
    localparam int DIV_BITS = 8;

    typedef struct {
        logic [IN_BITS-1:0] din;
        int                 code;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    dac_update_scheduler_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DIV_BITS(DIV_BITS)) bus ();

    dac_update_scheduler #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DIV_BITS(DIV_BITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SPI chip-select model ----------------
    logic spi_en   = 1'b1;
    int   cs_delay = 1;
    int   cs_low   = 19;

    initial begin
        bus.spi_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_en && bus.spi_start && bus.spi_cs) begin
                repeat (cs_delay) @(negedge clk);
                bus.spi_cs = 1'b0;
                repeat (cs_low) @(negedge clk);
                bus.spi_cs = 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [OUT_BITS-1:0] exp_q[$];
    int                  launch_cyc[$];
    logic [OUT_BITS-1:0] launch_dat[$];
    int                  done_cyc[$];
    int                  done_cnt   = 0;
    logic                sb_en      = 1'b1;
    logic                start_prev = 1'b0;
    logic [OUT_BITS-1:0] sent_dat   = 8'h80;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.spi_start && !start_prev) begin
            launch_cyc.push_back(cyc);
            launch_dat.push_back(bus.spi_data);
            sent_dat = bus.spi_data;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_launch: got data 0x%0h, expected no launch", bus.spi_data);
                end else begin
                    check("launch_data", int'(bus.spi_data), int'(exp_q.pop_front()));
                end
            end
        end else if (bus.busy) begin
            check("data_stable", int'(bus.spi_data), int'(sent_dat));
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        start_prev = bus.spi_start;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IN_BITS-1:0] v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
        end
    endtask

    task automatic wait_launches(input int target, input int limit);
        int n;
        n = 0;
        while (launch_cyc.size() < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (launch_cyc.size() < target) begin
            bad++;
            $display("FAIL launch_timeout: got %0d launches, expected %0d", launch_cyc.size(), target);
        end
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    vec_t vec[8];
    int   d0, l0, dd0, n;
    int   val_at[int];

    initial begin
        vec[0] = '{12'h07F, 'hFF};  //  127
        vec[1] = '{12'h000, 'h80};  //    0
        vec[2] = '{12'hFFF, 'h7F};  //   -1
        vec[3] = '{12'h1F4, 'hFF};  //  500
        vec[4] = '{12'hF9C, 'h1C};  // -100
        vec[5] = '{12'hF80, 'h00};  // -128
        vec[6] = '{12'h7FF, 'hFF};  // 2047
        vec[7] = '{12'h800, 'h00};  // -2048

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.rate_div = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_start", int'(bus.spi_start), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_data", int'(bus.spi_data), 'h80);
        check("rst_drop", int'(bus.drop_cnt), 0);
        check("rst_ready", int'(bus.in_ready), 1);
        reset_n = 1'b1;
        @(negedge clk);

        // asynchronous reset while waiting in START
        spi_en = 1'b0;
        exp_q.push_back(8'hE4);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd100;
        @(negedge clk);
        bus.in_data  = 12'd101;
        @(negedge clk);
        bus.in_data  = 12'd102;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_start", int'(bus.spi_start), 1);
        check("pre_rst_state", int'(bus.dbg_state), 1);
        check("pre_rst_data", int'(bus.spi_data), 'hE4);
        check("pre_rst_drop", int'(bus.drop_cnt), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_start", int'(bus.spi_start), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_data", int'(bus.spi_data), 'h80);
        check("async_rst_drop", int'(bus.drop_cnt), 0);
        check("async_rst_state", int'(bus.dbg_state), 0);
        @(negedge clk);
        reset_n = 1'b1;
        spi_en  = 1'b1;
        @(negedge clk);

        // conversion sweep, 20-clock transfers, tick every cycle
        cs_delay = 1;
        cs_low   = 19;
        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            l0 = launch_cyc.size();
            exp_q.push_back(vec[i].code[OUT_BITS-1:0]);
            send(vec[i].din);
            wait_done(d0 + 1, 60);
            repeat (3) @(negedge clk);
            check("sweep_done_pulses", done_cnt - d0, 1);
            check("sweep_launches", launch_cyc.size() - l0, 1);
        end

        // handshake: cs drops 3 clocks after start, held low 5 clocks
        cs_delay = 3;
        cs_low   = 5;
        d0 = done_cnt;
        exp_q.push_back(8'hAA);
        send(12'd42);
        for (int k = 0; k < 13; k++) begin
            check("hs_start", int'(bus.spi_start), int'(k >= 1 && k <= 4));
            check("hs_busy", int'(bus.busy), int'(k >= 1 && k <= 9));
            check("hs_done", int'(bus.done), int'(k == 10));
            if (k >= 1) check("hs_data", int'(bus.spi_data), 'hAA);
            @(negedge clk);
        end
        check("hs_done_pulses", done_cnt - d0, 1);

        // overwrite: five samples during one ACTIVE transfer
        cs_delay = 1;
        cs_low   = 19;
        d0 = done_cnt;
        exp_q.push_back(8'h8A);
        exp_q.push_back(8'h98);
        send(12'd10);
        repeat (4) @(negedge clk);
        check("ovr_state_active", int'(bus.dbg_state), 2);
        for (int j = 0; j < 5; j++) send(12'(20 + j));
        check("ovr_drop_cnt", int'(bus.drop_cnt), 4);
        wait_done(d0 + 2, 100);
        repeat (3) @(negedge clk);
        check("ovr_done_pulses", done_cnt - d0, 2);

        // drop counter saturation with a stalled transfer
        spi_en = 1'b0;
        exp_q.push_back(8'h83);
        bus.in_data  = 12'd3;
        bus.in_valid = 1'b1;
        repeat (300) @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sat_drop_cnt", int'(bus.drop_cnt), 255);
        check("sat_start_held", int'(bus.spi_start), 1);
        pulse_reset();
        spi_en = 1'b1;
        check("sat_rst_drop", int'(bus.drop_cnt), 0);

        // rate_div = 9, continuous samples: launches 30 clocks apart
        sb_en        = 1'b0;
        bus.rate_div = 8'd9;
        d0 = done_cnt;
        l0 = launch_cyc.size();
        n  = 0;
        bus.in_valid = 1'b1;
        while (launch_cyc.size() < l0 + 3 && n < 200) begin
            bus.in_data = 12'(cyc % 50);
            val_at[cyc] = cyc % 50;
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        wait_launches(l0 + 4, 100);
        wait_done(d0 + 4, 100);
        if (launch_cyc.size() >= l0 + 4) begin
            for (int i = 1; i < 4; i++)
                check("rate9_gap", launch_cyc[l0+i] - launch_cyc[l0+i-1], 30);
            for (int i = 0; i < 3; i++)
                check("rate9_data", int'(launch_dat[l0+i]), 128 + val_at[launch_cyc[l0+i] - 2]);
        end

        // rate_div = 0: relaunch the cycle after done
        repeat (3) @(negedge clk);
        bus.rate_div = 8'd0;
        d0  = done_cnt;
        dd0 = done_cyc.size();
        l0  = launch_cyc.size();
        n   = 0;
        bus.in_valid = 1'b1;
        while (launch_cyc.size() < l0 + 2 && n < 200) begin
            bus.in_data = 12'(cyc % 50);
            val_at[cyc] = cyc % 50;
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        wait_launches(l0 + 3, 100);
        wait_done(d0 + 3, 100);
        if (launch_cyc.size() >= l0 + 3 && done_cyc.size() >= dd0 + 2) begin
            check("rate0_gap1", launch_cyc[l0+1] - launch_cyc[l0], 22);
            check("rate0_gap2", launch_cyc[l0+2] - launch_cyc[l0+1], 22);
            check("rate0_after_done1", launch_cyc[l0+1], done_cyc[dd0] + 1);
            check("rate0_after_done2", launch_cyc[l0+2], done_cyc[dd0+1] + 1);
            for (int i = 0; i < 2; i++)
                check("rate0_data", int'(launch_dat[l0+i]), 128 + val_at[launch_cyc[l0+i] - 2]);
        end

        // repeated codes
        repeat (3) @(negedge clk);
        sb_en = 1'b1;
        pulse_reset();
        d0 = done_cnt;
        l0 = launch_cyc.size();
`ifdef DAC_SKIP_UNCHANGED_EN
        send(12'd0);
        repeat (30) @(negedge clk);
        check("skip_mid_launches", launch_cyc.size() - l0, 0);
        check("skip_mid_state", int'(bus.dbg_state), 0);
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h86);
        send(12'd5);
        repeat (40) @(negedge clk);
        send(12'd5);
        repeat (40) @(negedge clk);
        send(12'd6);
        repeat (40) @(negedge clk);
        check("skip_launches", launch_cyc.size() - l0, 2);
        check("skip_done_pulses", done_cnt - d0, 2);
`else
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h85);
        send(12'd5);
        repeat (40) @(negedge clk);
        send(12'd5);
        repeat (40) @(negedge clk);
        check("repeat_launches", launch_cyc.size() - l0, 2);
        check("repeat_done_pulses", done_cnt - d0, 2);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Sits directly upstream of the output-only SPI master that drives the external DAC.
- Takes signed controller output samples, saturates them and converts them to offset-binary DAC codes.
- Keeps the latest code pending, launches SPI transfers at a programmable update rate, and holds the SPI data word stable for the whole transfer.
- Counts samples overwritten before they could be sent.

Parameters:
- IN_BITS, 12, width of the signed two's-complement input sample.
- OUT_BITS, 8, DAC code width; must match the SPI master BITS; OUT_BITS <= IN_BITS.
- DIV_BITS, 8, width of the update-rate divider.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  IN_BITS  signed sample from the controller.
- in_valid  input  1  sample strobe; accepted on any cycle it is high.
- in_ready  output  1  constant 1; the latest sample always wins.
- rate_div  input  DIV_BITS  minimum clocks between launch opportunities, minus 1.
- spi_cs  input  1  chip select from the SPI master; high = idle, low = transfer in progress.
- spi_start  output  1  start request to the SPI master.
- spi_data  output  OUT_BITS  word to be shifted out by the SPI master.
- busy  output  1  high whenever the FSM is not IDLE.
- done  output  1  one-cycle pulse when a transfer completes.
- drop_cnt  output  8  saturating count of overwritten pending samples.

Behaviour:
- Reset (async, reset_n low):
  - FSM = IDLE; spi_start = 0; busy = 0; done = 0; drop_cnt = 0.
  - spi_data = midscale, i.e. 1 followed by OUT_BITS-1 zeros (0x80 for OUT_BITS=8).
  - pending_valid = 0; rate counter = 0.
  - Reset mid-transfer abandons the transfer immediately; the SPI master has its own reset.
- Conversion (combinational, applied on accept):
  - Clamp in_data to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - Take the low OUT_BITS bits and invert the MSB to get offset binary.
  - Example, IN=12, OUT=8: 0->0x80, -1->0x7F, 127->0xFF, 500->0xFF, -128->0x00, -2048->0x00.
- Pending register:
  - in_valid high: pending <= converted code, pending_valid <= 1, visible the next cycle.
  - If pending_valid is already 1 and not consumed this cycle, the old value is overwritten and drop_cnt increments, saturating at 255.
  - If in_valid arrives the same cycle a launch consumes pending: the new value becomes pending, pending_valid stays 1, and no drop is counted.
- Rate timer:
  - Down-counter; tick when it equals 0, then reload with rate_div. Otherwise decrement.
  - rate_div = 0 gives a tick every cycle.
  - The counter runs in every FSM state.
  - A tick missed while busy is not remembered; the FSM waits for the next tick.
- FSM states: IDLE, START, ACTIVE.
  - IDLE -> START when tick && pending_valid && spi_cs==1. On this edge: spi_data <= pending, pending_valid <= 0 (unless a simultaneous accept), spi_start <= 1.
  - START: hold spi_start=1 until spi_cs is sampled 0. On that edge: spi_start <= 0, go to ACTIVE.
  - ACTIVE: wait for spi_cs sampled 1. On that edge: done <= 1 for one cycle, go to IDLE.
- spi_data is held constant from the IDLE->START edge until the next launch; the SPI master indexes it bit-by-bit during the transfer.
- Minimum latency: in_valid at cycle N -> pending at N+1 -> spi_start high at N+2, given a tick at N+1, IDLE, and spi_cs high.
- A new launch can occur no earlier than the cycle after done.

Optional Feature:
- Macro: DAC_SKIP_UNCHANGED_EN.
- Defined:
  - Keep last_sent, reset to midscale.
  - At a launch decision where pending == last_sent: clear pending_valid, stay IDLE, assert no spi_start.
  - last_sent updates on every launch.
- Undefined: every pending value is transferred, including repeats; no last_sent register exists.

Test Plan:
- Reset state: assert reset_n low mid-START -> spi_start=0, busy=0, spi_data=0x80, drop_cnt=0 immediately, without waiting for a clock.
- Conversion sweep, rate_div=0, SPI model completes in 20 clocks: in_data 0, -1, 127, 500, -128, -2048, 2047 -> spi_data 0x80, 0x7F, 0xFF, 0xFF, 0x00, 0x00, 0xFF, one done pulse each.
- Handshake: SPI model drops cs 3 clocks after start -> spi_start stays high until cs low and falls on that edge; spi_data stable throughout; done pulses 1 cycle after cs returns high.
- Overwrite: five in_valid pulses during one ACTIVE transfer -> drop_cnt=4; only the fifth value is sent next; 300 overwrites -> drop_cnt saturates at 255.
- Rate: rate_div=9, continuous in_valid, 20-clock SPI -> launch spacing is the first tick at or after done, i.e. 30 clocks; rate_div=0 -> launch in the cycle after done.
- With DAC_SKIP_UNCHANGED_EN: after reset, send 0 -> no transfer; send 5, 5, 6 -> exactly two transfers, 0x85 and 0x86.
